// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes
// and the select codes seen by the ALU decoder and datapath muxes.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_HALT
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2 = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // States that hold the memory port and therefore arm the wait timer.
    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Counts stalled cycles of a memory access; flags the cycle on which the
// access has waited TIMEOUT cycles without completing.
module mem_wait_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,
    input  logic i_ready,
    output logic o_timeout
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;

    assign o_timeout = i_active && !i_ready && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (!i_active || i_ready || o_timeout)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: fetch/decode/execute/writeback
// sequencing over one ALU and one unified memory port.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int RET_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [6:0]       i_op,
    input  logic [2:0]       i_funct3,
    input  logic             i_cond,
    input  logic             i_mem_ready,
    output logic             o_mem_req,
    output logic             o_MemWrite,
    output logic             o_AdrSrc,
    output logic             o_IRWrite,
    output logic             o_PCWrite,
    output logic             o_RegWrite,
    output logic [1:0]       o_ALUSrcA,
    output logic [1:0]       o_ALUSrcB,
    output logic [1:0]       o_ALUOp,
    output logic [1:0]       o_ResultSrc,
    output logic [1:0]       o_ImmSrc,
    output logic             o_err,
    output logic [RET_W-1:0] o_retired
);
    state_t           r_state;
    logic             r_err;
    logic [RET_W-1:0] r_retired;
    logic             w_timeout;

    // funct3 is consumed by the ALU decoder for branch qualification, not here.
    logic w_unused_funct3;
    assign w_unused_funct3 = ^i_funct3;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_active  (is_mem_state(r_state)),
        .i_ready   (i_mem_ready),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_FETCH;
            r_err     <= 1'b0;
            r_retired <= '0;
        end else if (w_timeout) begin
            r_state <= S_HALT;
            r_err   <= 1'b1;
        end else begin
            case (r_state)
                S_FETCH:    if (i_mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (i_op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_R:         r_state <= S_EXEC_R;
                        OP_I:         r_state <= S_EXEC_I;
                        OP_BR:        r_state <= S_BRANCH;
                        OP_JAL:       r_state <= S_JAL;
                        default: begin
                            r_state <= S_HALT;
                            r_err   <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR:   r_state <= (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (i_mem_ready) r_state <= S_MEMWB;
                S_MEMWRITE: begin
                    if (i_mem_ready) begin
                        r_state   <= S_FETCH;
                        r_retired <= r_retired + RET_W'(1);
                    end
                end
                S_EXEC_R, S_EXEC_I: r_state <= S_ALUWB;
                S_JAL:      r_state <= S_ALUWB;
                S_MEMWB, S_ALUWB, S_BRANCH: begin
                    r_state   <= S_FETCH;
                    r_retired <= r_retired + RET_W'(1);
                end
                default:    r_state <= S_HALT;
            endcase
        end
    end

    logic       w_mem_req, w_memwrite, w_adrsrc, w_irwrite, w_pcwrite, w_regwrite;
    logic [1:0] w_srca, w_srcb, w_aluop, w_ressrc, w_immsrc;

    always_comb begin
        w_mem_req  = 1'b0;
        w_memwrite = 1'b0;
        w_adrsrc   = 1'b0;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_srca     = SRCA_PC;
        w_srcb     = SRCB_RD2;
        w_aluop    = ALUOP_ADD;
        w_ressrc   = RES_ALUOUT;
        w_immsrc   = IMM_I;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_srcb    = SRCB_4;
                w_ressrc  = RES_ALURES;
                w_irwrite = i_mem_ready;
                w_pcwrite = i_mem_ready;
            end
            S_DECODE: begin
                w_srca   = SRCA_OLDPC;
                w_srcb   = SRCB_IMM;
                w_immsrc = IMM_B;
            end
            S_MEMADR: begin
                w_srca   = SRCA_RD1;
                w_srcb   = SRCB_IMM;
                w_immsrc = (i_op == OP_SW) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adrsrc  = 1'b1;
            end
            S_MEMWB: begin
                w_ressrc   = RES_RDATA;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                w_mem_req  = 1'b1;
                w_memwrite = 1'b1;
                w_adrsrc   = 1'b1;
            end
            S_EXEC_R: begin
                w_srca  = SRCA_RD1;
                w_aluop = ALUOP_RTYPE;
            end
            S_EXEC_I: begin
                w_srca   = SRCA_RD1;
                w_srcb   = SRCB_IMM;
                w_immsrc = IMM_I;
                w_aluop  = ALUOP_ITYPE;
            end
            S_ALUWB:  w_regwrite = 1'b1;
            S_BRANCH: begin
                w_srca    = SRCA_RD1;
                w_aluop   = ALUOP_BRANCH;
                w_pcwrite = i_cond;
            end
            S_JAL: begin
                w_srca    = SRCA_OLDPC;
                w_srcb    = SRCB_4;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset masks the decode directly so enables drop the moment reset asserts.
    assign o_mem_req   = i_rst_n & w_mem_req;
    assign o_MemWrite  = i_rst_n & w_memwrite;
    assign o_AdrSrc    = i_rst_n & w_adrsrc;
    assign o_IRWrite   = i_rst_n & w_irwrite;
    assign o_PCWrite   = i_rst_n & w_pcwrite;
    assign o_RegWrite  = i_rst_n & w_regwrite;
    assign o_ALUSrcA   = i_rst_n ? w_srca   : 2'b00;
    assign o_ALUSrcB   = i_rst_n ? w_srcb   : 2'b00;
    assign o_ALUOp     = i_rst_n ? w_aluop  : 2'b00;
    assign o_ResultSrc = i_rst_n ? w_ressrc : 2'b00;
    assign o_ImmSrc    = i_rst_n ? w_immsrc : 2'b00;
    assign o_err       = r_err;
    assign o_retired   = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control signatures for
// each instruction class, memory stalls, timeout, illegal opcode and reset.
module tb_multicycle_controller;
    localparam int TIMEOUT = 4;
    localparam int RET_W   = 3;

    // {mem_req,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite, SrcA,SrcB,ALUOp,ResultSrc,ImmSrc}
    localparam logic [15:0] SG_ZERO  = 16'b000000_00_00_00_00_00;
    localparam logic [15:0] SG_F_RDY = 16'b100110_00_10_00_10_00;
    localparam logic [15:0] SG_F_IDL = 16'b100000_00_10_00_10_00;
    localparam logic [15:0] SG_DEC   = 16'b000000_01_01_00_00_10;
    localparam logic [15:0] SG_EXR   = 16'b000000_10_00_10_00_00;
    localparam logic [15:0] SG_EXI   = 16'b000000_10_01_11_00_00;
    localparam logic [15:0] SG_ALUWB = 16'b000001_00_00_00_00_00;
    localparam logic [15:0] SG_MA_LW = 16'b000000_10_01_00_00_00;
    localparam logic [15:0] SG_MA_SW = 16'b000000_10_01_00_00_01;
    localparam logic [15:0] SG_MRD   = 16'b101000_00_00_00_00_00;
    localparam logic [15:0] SG_MWB   = 16'b000001_00_00_00_01_00;
    localparam logic [15:0] SG_MWR   = 16'b111000_00_00_00_00_00;
    localparam logic [15:0] SG_BR_NT = 16'b000000_10_00_01_00_00;
    localparam logic [15:0] SG_BR_T  = 16'b000010_10_00_01_00_00;
    localparam logic [15:0] SG_JAL   = 16'b000010_01_10_00_00_00;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic [6:0]       i_op = 7'h00;
    logic [2:0]       i_funct3 = 3'b000;
    logic             i_cond = 1'b0;
    logic             i_mem_ready = 1'b0;
    logic             o_mem_req, o_MemWrite, o_AdrSrc, o_IRWrite, o_PCWrite, o_RegWrite;
    logic [1:0]       o_ALUSrcA, o_ALUSrcB, o_ALUOp, o_ResultSrc, o_ImmSrc;
    logic             o_err;
    logic [RET_W-1:0] o_retired;

    int n_cmp = 0;
    int n_mis = 0;

    multicycle_controller #(.TIMEOUT(TIMEOUT), .RET_W(RET_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_op        (i_op),
        .i_funct3    (i_funct3),
        .i_cond      (i_cond),
        .i_mem_ready (i_mem_ready),
        .o_mem_req   (o_mem_req),
        .o_MemWrite  (o_MemWrite),
        .o_AdrSrc    (o_AdrSrc),
        .o_IRWrite   (o_IRWrite),
        .o_PCWrite   (o_PCWrite),
        .o_RegWrite  (o_RegWrite),
        .o_ALUSrcA   (o_ALUSrcA),
        .o_ALUSrcB   (o_ALUSrcB),
        .o_ALUOp     (o_ALUOp),
        .o_ResultSrc (o_ResultSrc),
        .o_ImmSrc    (o_ImmSrc),
        .o_err       (o_err),
        .o_retired   (o_retired)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] sig();
        return {o_mem_req, o_MemWrite, o_AdrSrc, o_IRWrite, o_PCWrite, o_RegWrite,
                o_ALUSrcA, o_ALUSrcB, o_ALUOp, o_ResultSrc, o_ImmSrc};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        step();
        #1;
        n_cmp++;
        if (sig() !== SG_ZERO) begin
            n_mis++; $display("FAIL reset_sig got %b want %b", sig(), SG_ZERO);
        end
        n_cmp++;
        if ({o_err, o_retired} !== '0) begin
            n_mis++; $display("FAIL reset_err_ret got %b/%0d want 0/0", o_err, o_retired);
        end
        step();
        i_rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [15:0] exp [4] = '{SG_F_RDY, SG_DEC, SG_EXR, SG_ALUWB};
        i_op = 7'h33; i_mem_ready = 1'b1;  // add x3,x1,x2; ready left high throughout
        for (int k = 0; k < 4; k++) begin
            #1; n_cmp++;
            if (sig() !== exp[k]) begin
                n_mis++; $display("FAIL add c%0d got %b want %b", k, sig(), exp[k]);
            end
            step();
        end
        n_cmp++;
        if (o_retired !== 3'd1) begin
            n_mis++; $display("FAIL add_retired got %0d want 1", o_retired);
        end
    endtask

    task automatic test_lw_stall();
        logic [15:0] exp [8] = '{SG_F_RDY, SG_DEC, SG_MA_LW, SG_MRD, SG_MRD, SG_MRD, SG_MRD, SG_MWB};
        logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        i_op = 7'b0000011;
        for (int k = 0; k < 8; k++) begin
            i_mem_ready = rdy[k];
            #1; n_cmp++;
            if (sig() !== exp[k]) begin
                n_mis++; $display("FAIL lw c%0d got %b want %b", k, sig(), exp[k]);
            end
            step();
        end
        n_cmp++;
        if (o_retired !== 3'd2) begin
            n_mis++; $display("FAIL lw_retired got %0d want 2", o_retired);
        end
    endtask

    task automatic test_sw();
        logic [15:0] exp [4] = '{SG_F_RDY, SG_DEC, SG_MA_SW, SG_MWR};
        i_op = 7'b0100011; i_mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1; n_cmp++;
            if (sig() !== exp[k]) begin
                n_mis++; $display("FAIL sw c%0d got %b want %b", k, sig(), exp[k]);
            end
            step();
        end
        n_cmp++;
        if (o_retired !== 3'd3) begin
            n_mis++; $display("FAIL sw_retired got %0d want 3", o_retired);
        end
    endtask

    task automatic test_addi();
        logic [15:0] exp [4] = '{SG_F_RDY, SG_DEC, SG_EXI, SG_ALUWB};
        i_op = 7'b0010011; i_mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1; n_cmp++;
            if (sig() !== exp[k]) begin
                n_mis++; $display("FAIL addi c%0d got %b want %b", k, sig(), exp[k]);
            end
            step();
        end
        n_cmp++;
        if (o_retired !== 3'd4) begin
            n_mis++; $display("FAIL addi_retired got %0d want 4", o_retired);
        end
    endtask

    task automatic test_branch();
        logic [15:0] exp [6] = '{SG_F_RDY, SG_DEC, SG_BR_NT, SG_F_RDY, SG_DEC, SG_BR_T};
        logic        cnd [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        i_op = 7'b1100011; i_mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_cond = cnd[k];
            #1; n_cmp++;
            if (sig() !== exp[k]) begin
                n_mis++; $display("FAIL beq c%0d got %b want %b", k, sig(), exp[k]);
            end
            step();
        end
        i_cond = 1'b0;
        n_cmp++;
        if (o_retired !== 3'd6) begin
            n_mis++; $display("FAIL beq_retired got %0d want 6", o_retired);
        end
    endtask

    task automatic test_jal();
        logic [15:0] exp [4] = '{SG_F_RDY, SG_DEC, SG_JAL, SG_ALUWB};
        i_op = 7'b1101111; i_mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1; n_cmp++;
            if (sig() !== exp[k]) begin
                n_mis++; $display("FAIL jal c%0d got %b want %b", k, sig(), exp[k]);
            end
            step();
        end
        n_cmp++;
        if (o_retired !== 3'd7) begin
            n_mis++; $display("FAIL jal_retired got %0d want 7", o_retired);
        end
    endtask

    task automatic test_wrap();
        i_op = 7'b1100011; i_mem_ready = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (o_retired !== 3'd0) begin
            n_mis++; $display("FAIL wrap_retired got %0d want 0", o_retired);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] exp [5] = '{SG_F_RDY, SG_DEC, SG_ZERO, SG_ZERO, SG_ZERO};
        i_op = 7'h7F; i_mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1; n_cmp++;
            if (sig() !== exp[k]) begin
                n_mis++; $display("FAIL illegal c%0d got %b want %b", k, sig(), exp[k]);
            end
            step();
        end
        n_cmp++;
        if ({o_err, o_retired} !== {1'b1, 3'd0}) begin
            n_mis++; $display("FAIL illegal_err got %b/%0d want 1/0", o_err, o_retired);
        end
        i_rst_n = 1'b0;
        #1; n_cmp++;
        if (o_err !== 1'b0) begin
            n_mis++; $display("FAIL illegal_rst_err got %b want 0", o_err);
        end
        step();
        i_rst_n = 1'b1;
        #1; n_cmp++;
        if (sig() !== SG_F_RDY) begin
            n_mis++; $display("FAIL illegal_refetch got %b want %b", sig(), SG_F_RDY);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] exp [6] = '{SG_F_IDL, SG_F_IDL, SG_F_IDL, SG_F_IDL, SG_ZERO, SG_ZERO};
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1; i_mem_ready = 1'b0; i_op = 7'h33;
        for (int k = 0; k < 6; k++) begin
            #1; n_cmp++;
            if (sig() !== exp[k]) begin
                n_mis++; $display("FAIL timeout c%0d got %b want %b", k, sig(), exp[k]);
            end
            step();
        end
        n_cmp++;
        if (o_err !== 1'b1) begin
            n_mis++; $display("FAIL timeout_err got %b want 1", o_err);
        end
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_sw();
        logic [15:0] exp [4] = '{SG_F_RDY, SG_DEC, SG_MA_SW, SG_MWR};
        i_op = 7'b0100011;
        for (int k = 0; k < 4; k++) begin
            i_mem_ready = (k < 3);
            #1; n_cmp++;
            if (sig() !== exp[k]) begin
                n_mis++; $display("FAIL rstmid c%0d got %b want %b", k, sig(), exp[k]);
            end
            if (k < 3) step();
        end
        i_mem_ready = 1'b1;
        i_rst_n = 1'b0;
        #1; n_cmp++;
        if (o_MemWrite !== 1'b0 || o_mem_req !== 1'b0) begin
            n_mis++; $display("FAIL rstmid_drop got MemWrite=%b mem_req=%b want 0/0", o_MemWrite, o_mem_req);
        end
        step();
        i_rst_n = 1'b1; i_mem_ready = 1'b0;
        #1; n_cmp++;
        if (sig() !== SG_F_IDL || o_retired !== 3'd0) begin
            n_mis++; $display("FAIL rstmid_after got %b/%0d want %b/0", sig(), o_retired, SG_F_IDL);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_stall();
        test_sw();
        test_addi();
        test_branch();
        test_jal();
        test_wrap();
        test_illegal();
        test_timeout();
        test_reset_mid_sw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
